// File: rtl/myvr_fifo_pkg.sv
// Shared defaults and helpers for the myvr_fifo block.
//   MYVR_DW_DEFAULT    : default data width
//   MYVR_DEPTH_DEFAULT : default entry count
//   is_pow2()          : elaboration-time geometry check (power of two, >= 2)
package myvr_fifo_pkg;

    localparam int unsigned MYVR_DW_DEFAULT    = 32;
    localparam int unsigned MYVR_DEPTH_DEFAULT = 4;

    function automatic bit is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/myvr_fifo_mem.sv
// DEPTH x DW register array: one enabled write port, one asynchronous read port,
// all entries cleared on reset.
//   clk, rst      : clock, async active-low reset
//   we/waddr/wdata: write port
//   raddr/rdata   : combinational read port
module myvr_fifo_mem
    import myvr_fifo_pkg::*;
#(
    parameter int unsigned DW    = MYVR_DW_DEFAULT,
    parameter int unsigned DEPTH = MYVR_DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter string       NAME  = "myvr_fifo"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // Geometry check: pointer wrap arithmetic relies on a power-of-two depth.
    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("%s: DEPTH must be a power of two >= 2", NAME);
    end

    logic [DW-1:0] mem [DEPTH];

    // Storage array with reset clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/myvr_fifo.sv
// First-word-fall-through valid/ready FIFO. i_rdy, o_vld and the level flags are
// flops, so there is no combinational path from o_rdy to i_rdy.
//   clk, rst       : clock, async active-low reset
//   flush          : synchronous clear of both pointers (priority over push/pop)
//   i_vld/i_rdy/data_i : upstream handshake and word
//   o_vld/o_rdy/data_o : downstream handshake and head word
//   level/full/empty   : occupancy status
module myvr_fifo
    import myvr_fifo_pkg::*;
#(
    parameter int unsigned DW    = MYVR_DW_DEFAULT,
    parameter int unsigned DEPTH = MYVR_DEPTH_DEFAULT,
    parameter string       NAME  = "myvr_fifo",
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] data_i,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] data_o,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_nxt, rd_nxt, lvl_nxt;
    logic          full_nxt, empty_nxt;
    logic          push, pop, we;

    assign push = i_vld & i_rdy;
    assign pop  = o_vld & o_rdy;
    assign we   = push & ~flush;

    // Next pointers and flags; flags are registered from these.
    always_comb begin
        wr_nxt = wr_ptr;
        rd_nxt = rd_ptr;
        if (flush) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end else begin
            if (push) wr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_nxt = rd_ptr + PW'(1);
        end
        lvl_nxt   = wr_nxt - rd_nxt;
        empty_nxt = (wr_nxt == rd_nxt);
        full_nxt  = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end

    // Pointer and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            o_vld  <= 1'b0;
            i_rdy  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            level  <= lvl_nxt;
            empty  <= empty_nxt;
            full   <= full_nxt;
            o_vld  <= ~empty_nxt;
            i_rdy  <= ~full_nxt;
        end
    end

    myvr_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW),
        .NAME  (NAME)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_i),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (data_o)
    );

endmodule

// File: tb/tb_myvr_fifo.sv
// Directed bench for myvr_fifo (DW=32, DEPTH=4).
module tb_myvr_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        i_vld;
    logic        i_rdy;
    logic [31:0] data_i;
    logic        o_vld;
    logic        o_rdy;
    logic [31:0] data_o;
    logic [2:0]  level;
    logic        full;
    logic        empty;

    int n_chk  = 0;
    int n_fail = 0;

    myvr_fifo #(.DW(32), .DEPTH(4), .NAME("tb_fifo")) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .i_vld  (i_vld),
        .i_rdy  (i_rdy),
        .data_i (data_i),
        .o_vld  (o_vld),
        .o_rdy  (o_rdy),
        .data_o (data_o),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] lv, input logic ov,
                             input logic ir, input logic fu, input logic em);
        chk({tag, ".level"}, 32'(level), 32'(lv));
        chk({tag, ".o_vld"}, 32'(o_vld), 32'(ov));
        chk({tag, ".i_rdy"}, 32'(i_rdy), 32'(ir));
        chk({tag, ".full"},  32'(full),  32'(fu));
        chk({tag, ".empty"}, 32'(empty), 32'(em));
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0; data_i = '0;

        // 1. reset and idle
        #12;
        chk_state("rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst.data_o", data_o, 32'h0);
        rst = 1'b1;
        step(); step();
        chk_state("idle", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("idle.data_o", data_o, 32'h0);

        // 2. fill to full with o_rdy=0
        for (int k = 1; k <= 4; k++) begin
            i_vld = 1'b1; data_i = 32'hA0 + 32'(k);
            step();
            chk("fill.level", 32'(level), 32'(k));
            chk("fill.head", data_o, 32'hA1);
        end
        chk_state("full", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        data_i = 32'hA5;
        step(); step();
        chk("refuse.level", 32'(level), 32'd4);
        chk("refuse.head", data_o, 32'hA1);

        // 3. drain from full while A5 is held on the input
        o_rdy = 1'b1;
        step();                                   // pop A1, push refused
        chk_state("drain1", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("drain1.head", data_o, 32'hA2);
        step();                                   // pop A2, push A5
        i_vld = 1'b0;
        chk("drain2.level", 32'(level), 32'd3);
        chk("drain2.head", data_o, 32'hA3);
        step();
        chk("drain3.head", data_o, 32'hA4);
        step();
        chk("drain4.head", data_o, 32'hA5);
        chk("drain4.level", 32'(level), 32'd1);
        step();
        chk_state("drained", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        o_rdy = 1'b0;

        // 4. streaming push+pop, 20 words B0..B13
        i_vld = 1'b1; data_i = 32'hB0;
        step();
        chk("stream.prime", 32'(level), 32'd1);
        o_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 19) data_i = 32'hB0 + 32'(i + 1);
            else        i_vld = 1'b0;
            chk("stream.head", data_o, 32'hB0 + 32'(i));
            step();
            chk("stream.level", 32'(level), (i < 19) ? 32'd1 : 32'd0);
        end
        o_rdy = 1'b0;
        chk_state("stream.end", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // 5. flush at level 3 with concurrent push and pop
        i_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_i = 32'hC0 + 32'(k);
            step();
        end
        chk("preflush.level", 32'(level), 32'd3);
        flush = 1'b1; data_i = 32'hC3; o_rdy = 1'b1;
        step();
        flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0;
        chk_state("flush", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        i_vld = 1'b1; data_i = 32'hD0;
        step();
        i_vld = 1'b0;
        chk("postflush.level", 32'(level), 32'd1);
        chk("postflush.head", data_o, 32'hD0);
        o_rdy = 1'b1;
        step();
        o_rdy = 1'b0;
        chk("postflush.empty", 32'(empty), 32'd1);

        // 6. async reset mid-cycle at level 2
        i_vld = 1'b1;
        data_i = 32'hE0; step();
        data_i = 32'hE1; step();
        i_vld = 1'b0;
        chk("prerst.level", 32'(level), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk_state("async_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("async_rst.data_o", data_o, 32'h0);
        #2 rst = 1'b1;
        step();
        i_vld = 1'b1; data_i = 32'hF0;
        step();
        i_vld = 1'b0;
        chk("resume.level", 32'(level), 32'd1);
        chk("resume.head", data_o, 32'hF0);
        o_rdy = 1'b1;
        step();
        o_rdy = 1'b0;
        chk_state("resume.end", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
